// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scan driver with double-buffered, tear-free value updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       value,
  input  logic                      load,
  output logic [3:0]                number,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]    prescaler;
  logic [4*DIGITS-1:0] active;
  logic [4*DIGITS-1:0] pending;
  logic                pend_vld;
  logic                tick;
  logic                wrap;

  assign tick = (prescaler == LAST_PRE);
  assign wrap = tick && (digit_idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the value buffers are reset too, since a reset must discard any
      // pending value and restart the display showing zero.
      prescaler  <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
      active     <= '0;
      pending    <= '0;
      pend_vld   <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      frame_done <= wrap;
      if (tick) digit_idx <= wrap ? '0 : digit_idx + 1'b1;

      // A load on the wrap edge bypasses the pending buffer straight to display.
      if (load) begin
        pending  <= value;
        pend_vld <= !wrap;
        if (wrap) active <= value;
      end else if (wrap && pend_vld) begin
        active   <= pending;
        pend_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default before any conditional update,
    // so no latch can be inferred here.
    number         = 4'(active >> {digit_idx, 2'b00});
    an             = '1;
    an[digit_idx]  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // Blank a non-zero-position digit while it and everything left of it is zero.
    if ((digit_idx != '0) && ((active >> {digit_idx, 2'b00}) == '0)) an = '1;
`else
`endif
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux: directed scenarios plus random loads,
// compared cycle by cycle against a frame-level reference model.
module tb_display_scan_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  number;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset, displayed value, last loaded value.
  int          n;
  logic [15:0] disp;
  logic [15:0] last_val;
  bit          have_new;

  display_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .number(number), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n        = 0;
    disp     = '0;
    last_val = '0;
    have_new = 1'b0;
  endtask

  // One clock edge of the spec's rules: loads are captured, and at every frame
  // boundary the most recent load (including one on that very edge) goes live.
  task automatic model_edge(input logic ld, input logic [15:0] v);
    n++;
    if (ld) begin
      last_val = v;
      have_new = 1'b1;
    end
    if ((n % FRAME) == 0 && have_new) begin
      disp     = last_val;
      have_new = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int          slot;
    logic [3:0]  e_an;
    logic [3:0]  e_num;
    logic [15:0] upper;
    slot  = (n / SCAN_DIV) % DIGITS;
    e_num = 4'((disp >> (4 * slot)) & 16'hF);
    e_an  = 4'hF;
    e_an[slot] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    upper = disp >> (4 * slot);
    if (slot != 0 && upper == 16'h0) e_an = 4'hF;
`else
    upper = '0;
`endif
    check("digit_idx", 32'(digit_idx), 32'(slot));
    check("number", 32'(number), 32'(e_num));
    check("an", 32'(an), 32'(e_an));
    check("frame_done", 32'(frame_done), 32'((n > 0) && (n % FRAME == 0)));
  endtask

  task automatic step(input logic ld, input logic [15:0] v);
    load  = ld;
    value = v;
    @(posedge clk);
    model_edge(ld, v);
    #1;
    load  = 1'b0;
    value = $urandom;
    check_outputs();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Idle scan: zeros, anode rotation, frame_done at 16 and 32.
    idle(32);

    // Mid-frame load at cycle 5 appears only after the next wrap.
    apply_reset();
    idle(4);
    step(1'b1, 16'h1234);
    idle(30);

    // Two loads before a wrap: only the last one is ever shown.
    apply_reset();
    idle(2);
    step(1'b1, 16'hAAAA);
    idle(5);
    step(1'b1, 16'h5B0C);
    idle(26);

    // Load exactly on a wrap edge: bypass into the next frame.
    for (int i = 0; i < FRAME && ((n + 1) % FRAME) != 0; i++) step(1'b0, 16'h0);
    step(1'b1, 16'hBEEF);
    idle(2 * FRAME);

    // Reset during digit 2 with a pending load discards it.
    apply_reset();
    idle(8);
    step(1'b1, 16'h9876);
    step(1'b0, 16'h0);
    apply_reset();
    idle(FRAME + 4);

    // Values with leading zeros (blanked when the feature is built in).
    step(1'b1, 16'h0070);
    idle(2 * FRAME);
    step(1'b1, 16'h0000);
    idle(2 * FRAME);

    // Random loads, sometimes several per frame.
    for (int i = 0; i < 400; i++) begin
      logic ld;
      logic [15:0] v;
      ld = ($urandom_range(0, 5) == 0);
      v  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      step(ld, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
